// File: rtl/gold_despreader.sv
// Integrate-and-dump despreader for a Gold-coded chip stream, one result per code period.
// Optional low-confidence flag built only when THRESH_DETECT_EN is defined.
module gold_despreader #(
   parameter int N      = 63,
   parameter int ACC_W  = $clog2(N) + 2,
   parameter int THRESH = 48
) (
   input  logic                    clkin,
   input  logic                    rstn,
   input  logic                    chip_valid_i,
   input  logic                    chip_i,
   input  logic                    code_gold_i,
   input  logic                    strobe_i,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_bit,
   output logic signed [ACC_W-1:0] m_corr,
   output logic                    m_erase,
   output logic                    sync_err_o,
   output logic                    overflow_o
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(N - 1);

   typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] term_s, sum_s;
   logic                    issue_q, issue_d;
   logic signed [ACC_W-1:0] fsum_q, fsum_d;
   logic                    sync_q, sync_d;
   logic                    valid_q, valid_d;
   logic                    bit_q, bit_d;
   logic signed [ACC_W-1:0] corr_q, corr_d;
   logic                    erase_q, erase_d;
   logic                    ovf_q, ovf_d;
   logic                    erase_new_s;

   assign term_s = (chip_i == code_gold_i) ? ACC_W'(1) : {ACC_W{1'b1}};
   assign sum_s  = acc_q + term_s;

   // Period tracking: hunt for a strobe, then integrate N chips and check alignment at boundaries.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      issue_d = 1'b0;
      fsum_d  = fsum_q;
      sync_d  = 1'b0;
      case (state_q)
         HUNT: begin
            if (chip_valid_i && strobe_i) begin
               acc_d   = term_s;
               cnt_d   = CNT_W'(1);
               state_d = TRACK;
            end else begin
               state_d = HUNT;
            end
         end
         TRACK: begin
            if (!chip_valid_i) begin
               state_d = TRACK;
            end else if (strobe_i && (cnt_q != '0)) begin
               sync_d = 1'b1;
               acc_d  = term_s;
               cnt_d  = CNT_W'(1);
            end else if (!strobe_i && (cnt_q == '0)) begin
               sync_d  = 1'b1;
               acc_d   = '0;
               state_d = HUNT;
            end else if (cnt_q == LAST_CHIP) begin
               fsum_d  = sum_s;
               issue_d = 1'b1;
               cnt_d   = '0;
               acc_d   = '0;
            end else begin
               acc_d = sum_s;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = HUNT;
            cnt_d   = '0;
            acc_d   = '0;
         end
      endcase
   end

`ifdef THRESH_DETECT_EN
   localparam logic [ACC_W-1:0] THRESH_L = ACC_W'(THRESH);
   logic [ACC_W-1:0] mag_s;
   assign mag_s       = fsum_q[ACC_W-1] ? (ACC_W'(0) - fsum_q) : fsum_q;
   assign erase_new_s = (mag_s < THRESH_L);
`else
   assign erase_new_s = 1'b0;
`endif

   // One-deep result register; a result arriving while it is full and stalled is dropped.
   always_comb begin
      valid_d = valid_q;
      bit_d   = bit_q;
      corr_d  = corr_q;
      erase_d = erase_q;
      ovf_d   = 1'b0;
      if (issue_q) begin
         if (!valid_q || m_ready) begin
            valid_d = 1'b1;
            bit_d   = fsum_q[ACC_W-1];
            corr_d  = fsum_q;
            erase_d = erase_new_s;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && m_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Tracking state and the final-sum pipeline stage.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         acc_q   <= '0;
         issue_q <= 1'b0;
         fsum_q  <= '0;
         sync_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         issue_q <= issue_d;
         fsum_q  <= fsum_d;
         sync_q  <= sync_d;
      end
   end

   // Output register and overflow pulse.
   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         bit_q   <= 1'b0;
         corr_q  <= '0;
         erase_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         bit_q   <= bit_d;
         corr_q  <= corr_d;
         erase_q <= erase_d;
         ovf_q   <= ovf_d;
      end
   end

   assign m_valid    = valid_q;
   assign m_bit      = bit_q;
   assign m_corr     = corr_q;
   assign m_erase    = erase_q;
   assign sync_err_o = sync_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_gold_despreader.sv
// Scoreboard bench for gold_despreader: expected results queued at stimulus time, compared on handshake.
`timescale 1ns/1ps
module tb_gold_despreader;
   localparam int N      = 63;
   localparam int ACC_W  = $clog2(N) + 2;
   localparam int THRESH = 48;

   logic clkin = 1'b0;
   logic rstn = 1'b0;
   logic chip_valid_i = 1'b0, chip_i = 1'b0, code_gold_i = 1'b0, strobe_i = 1'b0;
   logic m_ready = 1'b1;
   logic m_valid, m_bit, m_erase, sync_err_o, overflow_o;
   logic signed [ACC_W-1:0] m_corr;

   typedef struct packed {
      logic                    b;
      logic signed [ACC_W-1:0] c;
      logic                    e;
   } res_t;

   res_t sb_q[$];
   int checks = 0, failures = 0;
   int sync_cnt = 0, ovf_cnt = 0, res_cnt = 0;

   always #5 clkin = ~clkin;

   gold_despreader #(.N(N), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
      .clkin(clkin), .rstn(rstn), .chip_valid_i(chip_valid_i), .chip_i(chip_i),
      .code_gold_i(code_gold_i), .strobe_i(strobe_i), .m_valid(m_valid), .m_ready(m_ready),
      .m_bit(m_bit), .m_corr(m_corr), .m_erase(m_erase), .sync_err_o(sync_err_o),
      .overflow_o(overflow_o)
   );

   // Scoreboard monitor: held results must match the queue head; a handshake pops it.
   always @(negedge clkin) begin
      if (rstn) begin
         if (sync_err_o) sync_cnt++;
         if (overflow_o) ovf_cnt++;
         if (m_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result got bit=%0b corr=%0d erase=%0b expected none", m_bit, m_corr, m_erase);
            end else begin
               if ({m_bit, m_corr, m_erase} !== sb_q[0]) begin
                  failures++;
                  $display("FAIL result got bit=%0b corr=%0d erase=%0b expected bit=%0b corr=%0d erase=%0b",
                           m_bit, m_corr, m_erase, sb_q[0].b, sb_q[0].c, sb_q[0].e);
               end
               if (m_ready) begin
                  void'(sb_q.pop_front());
                  res_cnt++;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic drive_chip(input bit c, input bit g, input bit s);
      chip_valid_i = 1'b1;
      chip_i       = c;
      code_gold_i  = g;
      strobe_i     = s;
      @(posedge clkin);
      #1;
      chip_valid_i = 1'b0;
      strobe_i     = 1'b0;
   endtask

   // First nmatch chips agree with the local code, the rest are inverted.
   task automatic send_period(input int nmatch, input int gapmax, input bit push);
      int   sum;
      bit   g;
      res_t r;
      sum = 0;
      for (int i = 0; i < N; i++) begin
         if (gapmax > 0) idle($urandom_range(gapmax, 1));
         g = 1'($urandom);
         sum += (i < nmatch) ? 1 : -1;
         if (i == N - 1 && push) begin
            r.b = (sum < 0);
            r.c = ACC_W'(sum);
`ifdef THRESH_DETECT_EN
            r.e = (((sum < 0) ? -sum : sum) < THRESH);
`else
            r.e = 1'b0;
`endif
            sb_q.push_back(r);
         end
         drive_chip((i < nmatch) ? g : ~g, g, i == 0);
      end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 300) begin
         idle(1);
         k++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d expected 0", sb_q.size());
      end
      idle(2);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle(2);
      checks++;
      if ({m_valid, m_bit, m_corr, m_erase, sync_err_o, overflow_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%0b bit=%0b corr=%0d erase=%0b sync=%0b ovf=%0b expected all 0",
                  m_valid, m_bit, m_corr, m_erase, sync_err_o, overflow_o);
      end
      @(negedge clkin);
      rstn = 1'b1;
      @(posedge clkin);
      #1;
   endtask

   task automatic test_match_latency();
      m_ready = 1'b1;
      send_period(N, 0, 1'b1);
      checks++;
      if (m_valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_early got m_valid=%0b expected 0", m_valid);
      end
      idle(1);
      checks++;
      if (m_valid !== 1'b1 || m_corr !== ACC_W'(63) || m_bit !== 1'b0) begin
         failures++;
         $display("FAIL latency_valid got valid=%0b corr=%0d bit=%0b expected 1 63 0", m_valid, m_corr, m_bit);
      end
      idle(1);
      checks++;
      if (m_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_one_cycle got m_valid=%0b expected 0", m_valid);
      end
      wait_drain();
      checks++;
      if (sync_cnt != 0 || ovf_cnt != 0) begin
         failures++;
         $display("FAIL no_pulses got sync=%0d ovf=%0d expected 0 0", sync_cnt, ovf_cnt);
      end
   endtask

   task automatic test_inverted_gaps();
      int r0;
      r0 = res_cnt;
      send_period(0, 3, 1'b1);
      wait_drain();
      send_period(10, 0, 1'b1);
      wait_drain();
      checks++;
      if (res_cnt - r0 != 2) begin
         failures++;
         $display("FAIL inverted_count got %0d expected 2", res_cnt - r0);
      end
   endtask

   task automatic test_sync();
      int s0, r0;
      s0 = sync_cnt;
      r0 = res_cnt;
      for (int i = 0; i < 20; i++) drive_chip(1'b1, 1'b1, i == 0);
      send_period(N, 0, 1'b1);
      wait_drain();
      checks++;
      if (sync_cnt - s0 != 1 || res_cnt - r0 != 1) begin
         failures++;
         $display("FAIL early_strobe got sync=%0d results=%0d expected 1 1", sync_cnt - s0, res_cnt - r0);
      end
      for (int i = 0; i < N; i++) drive_chip(1'b0, 1'b0, 1'b0);
      idle(4);
      checks++;
      if (sync_cnt - s0 != 2 || res_cnt - r0 != 1 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL missing_strobe got sync=%0d results=%0d valid=%0b expected 2 1 0",
                  sync_cnt - s0, res_cnt - r0, m_valid);
      end
      send_period(N, 0, 1'b1);
      wait_drain();
      checks++;
      if (res_cnt - r0 != 2 || sync_cnt - s0 != 2) begin
         failures++;
         $display("FAIL resync got results=%0d sync=%0d expected 2 2", res_cnt - r0, sync_cnt - s0);
      end
   endtask

   task automatic test_overflow();
      int o0;
      o0 = ovf_cnt;
      m_ready = 1'b0;
      send_period(N, 0, 1'b1);
      send_period(N, 0, 1'b0);
      idle(4);
      checks++;
      if (ovf_cnt - o0 != 1 || m_valid !== 1'b1 || m_corr !== ACC_W'(63)) begin
         failures++;
         $display("FAIL overflow got ovf=%0d valid=%0b corr=%0d expected 1 1 63", ovf_cnt - o0, m_valid, m_corr);
      end
      m_ready = 1'b1;
      wait_drain();
      checks++;
      if (m_valid !== 1'b0) begin
         failures++;
         $display("FAIL overflow_drain got m_valid=%0b expected 0", m_valid);
      end
   endtask

   task automatic test_midperiod_reset();
      m_ready = 1'b0;
      send_period(N, 0, 1'b1);
      for (int i = 0; i < 30; i++) drive_chip(1'b1, 1'b1, i == 0);
      checks++;
      if (m_valid !== 1'b1) begin
         failures++;
         $display("FAIL held_before_reset got m_valid=%0b expected 1", m_valid);
      end
      #2;
      rstn = 1'b0;
      sb_q.delete();
      #1;
      checks++;
      if ({m_valid, m_bit, m_corr, m_erase, sync_err_o, overflow_o} !== '0) begin
         failures++;
         $display("FAIL async_reset got valid=%0b corr=%0d expected 0 0", m_valid, m_corr);
      end
      m_ready = 1'b1;
      @(negedge clkin);
      rstn = 1'b1;
      @(posedge clkin);
      #1;
      send_period(N - 5, 2, 1'b1);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_match_latency();
      test_inverted_gaps();
      test_sync();
      test_overflow();
      test_midperiod_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gold_despreader.md
Name: gold_despreader

Overview:
- Sits directly downstream of the Gold code generator.
- Correlates a received 1-bit chip stream against the locally generated Gold chips, integrating and dumping over one code period of N chips.
- Each completed period yields one despread data bit plus a signed correlation value on a valid/ready output.
- Period alignment comes from the generator's strobe, which marks the first chip of each code period.

Parameters:
N, 63, chips per code period (Gold code length)
ACC_W, $clog2(N)+2, width of signed correlation accumulator (holds -N..+N)
THRESH, 48, minimum |correlation| for a confident decision (used only with optional feature)

Ports:
clkin  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
chip_valid_i  input  1  received chip and local Gold chip valid this cycle
chip_i  input  1  received (spread) chip
code_gold_i  input  1  local Gold chip, aligned with chip_i
strobe_i  input  1  high with the first chip of a code period; sampled only when chip_valid_i=1
m_valid  output  1  result register holds an unread result
m_ready  input  1  downstream accepts result
m_bit  output  1  despread data bit
m_corr  output  ACC_W  signed correlation of the period (matches minus mismatches)
m_erase  output  1  low-confidence flag (optional feature)
sync_err_o  output  1  one-cycle pulse on period misalignment
overflow_o  output  1  one-cycle pulse when a result is dropped

Behaviour:
- Reset (rstn=0, asynchronous): state=HUNT, chip counter=0, accumulator=0. All outputs=0: m_valid, m_bit, m_corr, m_erase, sync_err_o, overflow_o.
- Reset is honoured mid-period: the partial accumulation is discarded and no result is produced.
- Chip update term: +1 if chip_i==code_gold_i, else -1. Cycles with chip_valid_i=0 hold all state; gaps of any length are legal.
- State HUNT:
  - Ignores chips until a chip arrives with chip_valid_i=1 and strobe_i=1.
  - That chip is chip 0: accumulator=term, counter=1, go to TRACK.
- State TRACK, on each valid chip:
  - If strobe_i=1 and counter!=0 (strobe arrives early): pulse sync_err_o, discard the partial sum, restart with this chip as chip 0 (accumulator=term, counter=1).
  - If counter==0 and strobe_i=0 (strobe missing at a period boundary): pulse sync_err_o, go to HUNT, discard the chip.
  - If counter==N-1: final sum = accumulator+term. Issue the result, set counter=0, clear the accumulator, stay in TRACK.
  - Otherwise: accumulate and increment counter.
- Result:
  - m_corr = final sum.
  - m_bit = 1 if final sum<0, else 0.
  - Ties (sum 0) are impossible for odd N; if N is even, 0 decodes as bit 0.
- Latency: m_valid rises on the clock edge after the edge that samples chip N-1, i.e. one cycle.
- Output register is one-deep:
  - Holds m_bit, m_corr, m_erase stable while m_valid=1 and m_ready=0.
  - m_valid & m_ready drops m_valid next cycle, unless a new result loads in the same cycle, in which case m_valid stays 1 with the new data.
- New result while the register is full and m_ready=0: the new result is dropped, the old result is kept, overflow_o pulses for one cycle.
- Simultaneous sync error and final chip cannot occur, since strobe on counter N-1 is itself an error: no result is issued in that case.
- sync_err_o and overflow_o are registered, exactly one cycle per event.
- Arithmetic: two's complement in ACC_W bits, no saturation needed (|sum|<=N).

Optional Feature:
- Macro THRESH_DETECT_EN.
- When defined: m_erase is loaded with each result as 1 iff |final sum| < THRESH, else 0.
- When undefined: the magnitude compare is not built and m_erase is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then 63 valid chips with chip_i=code_gold_i, strobe_i on chip 0, m_ready=1 -> m_valid high for 1 cycle, one cycle after last chip, m_bit=0, m_corr=+63, no error pulses.
- Same stimulus with chip_i=~code_gold_i, random 1-3 cycle chip_valid_i gaps -> m_bit=1, m_corr=-63.
- Inverted period with 10 chips uncorrupted-matching (10 matches, 53 mismatches) -> m_corr=-43, m_bit=1. With THRESH_DETECT_EN and THRESH=48, m_erase=1; without the macro, m_erase=0.
- Strobe re-asserted on chip 20 of a period -> sync_err_o 1-cycle pulse, no result; following 63 matching chips -> m_corr=+63. Next period start without strobe -> sync_err_o pulse, state HUNT, no result until the next strobe.
- m_ready=0 across two full matching periods -> first result (+63) held stable, overflow_o pulses once at second completion. m_ready=1 -> first result consumed, m_valid falls.
- rstn pulsed low at chip 30 -> all outputs 0 immediately; after release, the next strobed full period produces one correct result.
